// File: rtl/handshake_fifo.sv
// Elastic req/ack buffer: prefetches up to `depth` words from an upstream provider
// and serves them to a downstream requester as registered one-cycle ack pulses.
module handshake_fifo #(
    parameter int data_width = 32,
    parameter int depth      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    req_l,
    input  logic                    ack_l,
    input  logic [data_width-1:0]   din,
    input  logic                    req_r,
    output logic                    ack_r,
    output logic [data_width-1:0]   dout,
    output logic [$clog2(depth):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] depth_c = cw'(depth);
    localparam logic [cw-1:0] one_c   = cw'(1);
    localparam logic [aw-1:0] step_c  = aw'(1);

    logic [data_width-1:0] mem [depth];
    logic [aw-1:0]         wp;
    logic [aw-1:0]         rp;
    logic                  wr;
    logic                  rd;
    logic                  req_l_nxt;
    logic [cw-1:0]         count_nxt;

    // An ack only counts against an outstanding request; a stray ack is ignored.
    assign wr = req_l & ack_l;
    // Reads are gated by the registered count, so a word never bypasses storage.
    assign rd = req_r & ~ack_r & (count != '0);

    always_comb begin
        count_nxt = count;
        if (wr && !rd) begin
            count_nxt = count + one_c;
        end else if (rd && !wr) begin
            count_nxt = count - one_c;
        end
    end

    // The outstanding request reserves a slot, so it holds until its ack arrives.
    always_comb begin
        req_l_nxt = 1'b0;
        if (wr) begin
            req_l_nxt = 1'b0;
        end else if (req_l) begin
            req_l_nxt = 1'b1;
        end else if (!ack_l && (count_nxt < depth_c)) begin
            req_l_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_l <= 1'b0;
            ack_r <= 1'b0;
            dout  <= '0;
            count <= '0;
            wp    <= '0;
            rp    <= '0;
        end else begin
            req_l <= req_l_nxt;
            ack_r <= rd;
            count <= count_nxt;
            if (wr) begin
                wp <= wp + step_c;
            end
            if (rd) begin
                dout <= mem[rp];
                rp   <= rp + step_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wp] <= din;
        end
    end

    assign full  = (count == depth_c);
    assign empty = (count == '0);

endmodule
